// File: rtl/mux_scan_serializer_pkg.sv
// Shared constants for the mux scan serializer: FSM state encoding and channel count.
package mux_scan_serializer_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/mux_scan_serializer.sv
// Steps a 4-to-1 mux select through every channel, samples the settled mux output
// into a capture word and presents the assembled word on a valid/ready handshake.
module mux_scan_serializer
  import mux_scan_serializer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [1:0]        sel,
  input  logic              mux_out,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NUM_CH-1:0] data_out
);

  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [1:0]       LAST_CH = 2'(NUM_CH - 1);

  state_t             state_q;
  logic [1:0]         sel_q;
  logic [1:0]         sel_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_CH-2:0]  capture_q;
  logic [NUM_CH-1:0]  data_q;
  logic               valid_q;
  logic               busy_q;

  assign sel_d = sel_q + 2'd1;

  // The last channel is written straight into data_q, so capture only holds channels 0..2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      capture_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sel_q <= '0;
          if (start) begin
            state_q   <= ST_SETTLE;
            cnt_q     <= RELOAD;
            capture_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (sel_q != LAST_CH) begin
            capture_q[sel_q] <= mux_out;
            sel_q            <= sel_d;
            cnt_q            <= RELOAD;
            state_q          <= ST_SETTLE;
          end else begin
            data_q  <= {mux_out, capture_q};
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Self-checking bench: two serializers (settle 1 and settle 3) each reading a behavioural mux.
module tb_mux_scan_serializer;

   typedef struct {
      logic [3:0] pattern;
      logic [3:0] expected;
   } vec_t;

   logic       clock = 1'b0;
   logic       reset;

   logic       start1, ready1, mux1, busy1, valid1;
   logic [1:0] sel1;
   logic [3:0] data1, pat1;

   logic       start3, ready3, mux3, busy3, valid3;
   logic [1:0] sel3;
   logic [3:0] data3, pat3;

   logic [3:0] expQ1[$];
   logic [3:0] expQ3[$];
   logic       prevValid1 = 1'b0;
   logic       prevValid3 = 1'b0;

   int checks = 0;
   int errors = 0;

   vec_t vecs[4];

   assign mux1 = pat1[sel1];
   assign mux3 = pat3[sel3];

   always #5 clock = ~clock;

   mux_scan_serializer #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
      .clk(clock), .rst(reset), .start(start1), .sel(sel1), .mux_out(mux1),
      .busy(busy1), .out_valid(valid1), .out_ready(ready1), .data_out(data1)
   );

   mux_scan_serializer #(.SETTLE_CYCLES(3), .CNT_W(4)) dut3 (
      .clk(clock), .rst(reset), .start(start3), .sel(sel3), .mux_out(mux3),
      .busy(busy3), .out_valid(valid3), .out_ready(ready3), .data_out(data3)
   );

   function automatic void checkOutput(string name, int actual, int required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
      end
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] pattern, input logic [3:0] expected);
      pat1 = pattern;
      expQ1.push_back(expected);
   endtask

   // Advances until out_valid of the settle-1 instance is seen high, bounded by maxCycles.
   task automatic waitValid1(input int maxCycles, input string name);
      int n = 0;
      do begin
         step();
         n++;
      end while (!valid1 && n < maxCycles);
      if (!valid1) checkOutput({name, "_timeout"}, 0, 1);
   endtask

   // Scoreboard for the settle-1 instance: each rising out_valid pops one expected word.
   always @(posedge clock) begin
      #1;
      if (!reset && valid1 && !prevValid1) begin
         if (expQ1.size() == 0) checkOutput("dut1_unexpected_valid", 1, 0);
         else checkOutput("dut1_data", int'(data1), int'(expQ1.pop_front()));
      end
      prevValid1 = valid1;
   end

   // Scoreboard for the settle-3 instance.
   always @(posedge clock) begin
      #1;
      if (!reset && valid3 && !prevValid3) begin
         if (expQ3.size() == 0) checkOutput("dut3_unexpected_valid", 1, 0);
         else checkOutput("dut3_data", int'(data3), int'(expQ3.pop_front()));
      end
      prevValid3 = valid3;
   end

   // Hard stop so a stuck design still ends with a report.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      vecs[0] = '{pattern: 4'b0011, expected: 4'b0011};
      vecs[1] = '{pattern: 4'b1100, expected: 4'b1100};
      vecs[2] = '{pattern: 4'b0101, expected: 4'b0101};
      vecs[3] = '{pattern: 4'b1110, expected: 4'b1110};

      reset = 1'b1;
      start1 = 1'b0; ready1 = 1'b1; pat1 = 4'b0000;
      start3 = 1'b0; ready3 = 1'b1; pat3 = 4'b0000;
      #2;
      checkOutput("reset_sel", int'(sel1), 0);
      checkOutput("reset_busy", int'(busy1), 0);
      checkOutput("reset_valid", int'(valid1), 0);
      checkOutput("reset_data", int'(data1), 0);
      step();
      step();
      @(negedge clock);
      reset = 1'b0;
      step();

      // Single scan, pattern 1010, consumer always ready.
      applyStimulus(4'b1010, 4'b1010);
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checkOutput("scan_sel", int'(sel1), i / 2);
         checkOutput("scan_busy", int'(busy1), 1);
         checkOutput("scan_valid_low", int'(valid1), 0);
         step();
      end
      checkOutput("scan_valid_high", int'(valid1), 1);
      checkOutput("scan_busy_done", int'(busy1), 0);
      checkOutput("scan_hold_sel", int'(sel1), 3);
      step();
      checkOutput("scan_valid_one_cycle", int'(valid1), 0);
      checkOutput("scan_idle_sel", int'(sel1), 0);

      // Back-pressure: result must hold and start pulses must be ignored.
      ready1 = 1'b0;
      applyStimulus(4'b0110, 4'b0110);
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      repeat (8) step();
      for (int i = 0; i < 20; i++) begin
         start1 = (i % 3 == 0);
         checkOutput("bp_valid", int'(valid1), 1);
         checkOutput("bp_data", int'(data1), 4'b0110);
         checkOutput("bp_sel", int'(sel1), 3);
         step();
      end
      checkOutput("bp_still_valid", int'(valid1), 1);
      // Handshake and start together: start is dropped, the next one from IDLE is taken.
      ready1 = 1'b1;
      start1 = 1'b1;
      step();
      checkOutput("bp_release_valid", int'(valid1), 0);
      checkOutput("bp_release_busy", int'(busy1), 0);
      checkOutput("bp_release_sel", int'(sel1), 0);
      expQ1.push_back(4'b0110);
      step();
      start1 = 1'b0;
      checkOutput("restart_from_idle", int'(busy1), 1);
      waitValid1(20, "restart");
      step();

      // Start during SETTLE of channel 2 plus a pattern change after channel 1 was sampled.
      applyStimulus(4'b0001, 4'b1101);
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      repeat (4) step();
      checkOutput("midscan_sel2", int'(sel1), 2);
      pat1 = 4'b1111;
      start1 = 1'b1;
      step();
      checkOutput("midscan_no_restart_sel", int'(sel1), 2);
      checkOutput("midscan_busy", int'(busy1), 1);
      checkOutput("midscan_data_unchanged", int'(data1), 4'b0110);
      start1 = 1'b0;
      step();
      checkOutput("midscan_sel3", int'(sel1), 3);
      waitValid1(10, "midscan");
      step();

      // Async reset in the middle of the channel-1 sample cycle.
      pat1 = 4'b1111;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      repeat (3) step();
      checkOutput("prereset_sel", int'(sel1), 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_reset_sel", int'(sel1), 0);
      checkOutput("async_reset_busy", int'(busy1), 0);
      checkOutput("async_reset_valid", int'(valid1), 0);
      checkOutput("async_reset_data", int'(data1), 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (10) step();
      checkOutput("post_reset_valid", int'(valid1), 0);
      checkOutput("post_reset_data", int'(data1), 0);
      checkOutput("post_reset_busy", int'(busy1), 0);

      // Settle of 3: four cycles per channel, result sixteen cycles after start.
      pat3 = 4'b1001;
      expQ3.push_back(4'b1001);
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         checkOutput("s3_sel", int'(sel3), i / 4);
         checkOutput("s3_valid_low", int'(valid3), 0);
         step();
      end
      checkOutput("s3_valid_high", int'(valid3), 1);
      step();
      checkOutput("s3_valid_one_cycle", int'(valid3), 0);

      // Back-to-back scans with start held high, pattern changed while each result is held.
      ready1 = 1'b1;
      start1 = 1'b1;
      for (int n = 0; n < 4; n++) begin
         applyStimulus(vecs[n].pattern, vecs[n].expected);
         waitValid1(20, "b2b");
      end
      start1 = 1'b0;
      step();
      step();
      checkOutput("b2b_idle_busy", int'(busy1), 0);

      checkOutput("dut1_queue_empty", expQ1.size(), 0);
      checkOutput("dut3_queue_empty", expQ3.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
